// File: rtl/cp0_pkg.sv
// ---------------------------------------------------------------------------
// cp0_pkg -- shared constants for the CP0 exception/interrupt controller.
//
// Contents:
//   - CP0 register select numbers (mfc0/mtc0 rd field)
//   - Bit positions of the SR and Cause fields
//   - ExcCode values used by the pipeline
//   - takeEpc(): return-address computation for an exception take
// ---------------------------------------------------------------------------
package cp0_pkg;

  // Register selects
  localparam logic [4:0] selBadVAddr = 5'd8;
  localparam logic [4:0] selSr       = 5'd12;
  localparam logic [4:0] selCause    = 5'd13;
  localparam logic [4:0] selEpc      = 5'd14;
  localparam logic [4:0] selPrid     = 5'd15;

  // SR fields
  localparam int bitIe    = 0;
  localparam int bitExl   = 1;
  localparam int bitImLsb = 10;

  // Cause fields
  localparam int bitExcLsb = 2;
  localparam int bitIpLsb  = 10;
  localparam int bitBd     = 31;

  typedef enum logic [4:0] {
    excInt  = 5'd0,
    excAdEL = 5'd4,
    excAdES = 5'd5,
    excRI   = 5'd10,
    excOv   = 5'd12
  } excCode_e;

  // An instruction in a delay slot restarts at its branch, one word back.
  // The low two bits are cleared so EPC is always word aligned.
  function automatic logic [31:0] takeEpc(input logic [31:0] pc, input logic bd);
    logic [31:0] ret;
    ret      = bd ? (pc - 32'd4) : pc;
    ret[1:0] = 2'b00;
    return ret;
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl_int_sync.sv
// ---------------------------------------------------------------------------
// int_sync -- multi-flop synchroniser for a bus of asynchronous level inputs.
//
// Parameters:
//   WIDTH   number of independent lines
//   STAGES  flops per line (>= 1)
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset, clears every stage
//   asyncIn  level inputs, asynchronous to clk
//   syncOut  inputs delayed by STAGES clock edges
// ---------------------------------------------------------------------------
module int_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] asyncIn,
  output logic [WIDTH-1:0] syncOut
);

  logic [WIDTH-1:0] stageQ [STAGES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) stageQ[i] <= '0;
    end else begin
      stageQ[0] <= asyncIn;
      for (int i = 1; i < STAGES; i++) stageQ[i] <= stageQ[i-1];
    end
  end

  assign syncOut = stageQ[STAGES-1];

endmodule

// File: rtl/cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// cp0_exc_ctrl -- CP0 exception and interrupt controller (SR, Cause, EPC,
// PRId, optional BadVAddr).
//
// Build option: define CP0_BADVADDR_EN to implement BadVAddr at select 8.
//   Without it select 8 reads 0 and bad_addr_m is ignored.
//
// Parameters:
//   NUM_HWINT    hardware interrupt lines (1..6)
//   SYNC_STAGES  synchroniser flops per hw_int line (1..3)
//   PRID_VALUE   constant returned by PRId
// Ports:
//   clk, reset   clock; asynchronous active-low reset
//   hw_int       level interrupt requests, asynchronous to clk
//   pc_m, bd_m   M-stage PC and branch-delay-slot flag
//   exc_code_m   M-stage exception code, 0 = none
//   bad_addr_m   faulting address (BadVAddr builds only)
//   we, wr_sel, wr_data   mtc0 write port
//   rd_sel, rd_data       mfc0 read port (combinational, pre-edge state)
//   eret         eret in M stage, clears EXL
//   int_req      take an exception/interrupt this cycle
//   epc          return address (bypasses a same-cycle mtc0 to EPC)
//   exl          SR.EXL
// ---------------------------------------------------------------------------
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter int          NUM_HWINT   = 6,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] PRID_VALUE  = 32'h2020_0707
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_HWINT-1:0] hw_int,
  input  logic [31:0]          pc_m,
  input  logic                 bd_m,
  input  logic [4:0]           exc_code_m,
  input  logic [31:0]          bad_addr_m,
  input  logic                 we,
  input  logic [4:0]           wr_sel,
  input  logic [31:0]          wr_data,
  input  logic [4:0]           rd_sel,
  output logic [31:0]          rd_data,
  input  logic                 eret,
  output logic                 int_req,
  output logic [31:0]          epc,
  output logic                 exl
);

  logic [NUM_HWINT-1:0] srIm;
  logic                 srExl;
  logic                 srIe;
  logic                 causeBd;
  logic [NUM_HWINT-1:0] causeIp;
  logic [4:0]           causeExc;
  logic [31:0]          epcReg;

  logic intPending;
  logic excPending;
  logic takeExc;
  logic wrAccept;

  // The last synchroniser stage is the Cause.IP register itself, so IP
  // follows the line level with no extra cycle and no latching.
  int_sync #(
    .WIDTH  (NUM_HWINT),
    .STAGES (SYNC_STAGES)
  ) uIntSync (
    .clk     (clk),
    .reset   (reset),
    .asyncIn (hw_int),
    .syncOut (causeIp)
  );

  assign intPending = srIe & ~srExl & (|(causeIp & srIm));
  assign excPending = (exc_code_m != 5'd0) & ~srExl;
  assign takeExc    = intPending | excPending;
  // A take in the same cycle wins over an mtc0.
  assign wrAccept   = we & ~takeExc;

  // Combinational outputs are forced low while reset is held, since the
  // M-stage inputs may still carry an exception request.
  assign int_req = reset & takeExc;
  assign exl     = srExl;
  assign epc     = !reset ? 32'd0 :
                   (we && (wr_sel == selEpc)) ? wr_data : epcReg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      srIm     <= '0;
      srExl    <= 1'b0;
      srIe     <= 1'b0;
      causeBd  <= 1'b0;
      causeExc <= 5'd0;
      epcReg   <= 32'd0;
    end else if (takeExc) begin
      srExl    <= 1'b1;
      causeBd  <= bd_m;
      causeExc <= intPending ? 5'(excInt) : exc_code_m;
      epcReg   <= takeEpc(pc_m, bd_m);
    end else begin
      if (wrAccept && (wr_sel == selSr)) begin
        srIm  <= wr_data[bitImLsb +: NUM_HWINT];
        srExl <= wr_data[bitExl];
        srIe  <= wr_data[bitIe];
      end
      if (wrAccept && (wr_sel == selEpc)) begin
        epcReg <= wr_data;
      end
      // Placed after the SR write so eret has the last word on EXL.
      if (eret) begin
        srExl <= 1'b0;
      end
    end
  end

`ifdef CP0_BADVADDR_EN
  logic [31:0] badVAddr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      badVAddr <= 32'd0;
    end else if (takeExc && !intPending &&
                 ((exc_code_m == 5'(excAdEL)) || (exc_code_m == 5'(excAdES)))) begin
      badVAddr <= bad_addr_m;
    end
  end
`else
  logic unusedBadAddr;
  assign unusedBadAddr = ^bad_addr_m;
`endif

  // Read mux reflects register state before the edge; no write bypass.
  always_comb begin
    rd_data = 32'd0;
    case (rd_sel)
      selSr: begin
        rd_data[bitImLsb +: NUM_HWINT] = srIm;
        rd_data[bitExl]                = srExl;
        rd_data[bitIe]                 = srIe;
      end
      selCause: begin
        rd_data[bitBd]                 = causeBd;
        rd_data[bitIpLsb +: NUM_HWINT] = causeIp;
        rd_data[bitExcLsb +: 5]        = causeExc;
      end
      selEpc:  rd_data = epcReg;
      selPrid: rd_data = PRID_VALUE;
`ifdef CP0_BADVADDR_EN
      selBadVAddr: rd_data = badVAddr;
`else
      selBadVAddr: rd_data = 32'd0;
`endif
      default: rd_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cp0_exc_ctrl -- self-checking bench for cp0_exc_ctrl.
// A register read/write vector table plus hand-written sequences for
// interrupt latency, exception take, priority, eret bypass, reset during a
// take, BadVAddr and a narrow NUM_HWINT=2 instance.
// ---------------------------------------------------------------------------
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  hwInt;
  logic [31:0] pcM;
  logic        bdM;
  logic [4:0]  excCodeM;
  logic [31:0] badAddrM;
  logic        we;
  logic [4:0]  wrSel;
  logic [31:0] wrData;
  logic [4:0]  rdSel;
  logic [31:0] rdData;
  logic        eret;
  logic        intReq;
  logic [31:0] epc;
  logic        exl;

  logic [1:0]  hwInt2;
  logic [4:0]  excCode2;
  logic        we2;
  logic [4:0]  wrSel2;
  logic [31:0] wrData2;
  logic [4:0]  rdSel2;
  logic [31:0] rdData2;
  logic        eret2;
  logic        intReq2;
  logic [31:0] epc2;
  logic        exl2;

  always #5 clk = ~clk;

  cp0_exc_ctrl dut (
    .clk(clk), .reset(reset), .hw_int(hwInt), .pc_m(pcM), .bd_m(bdM),
    .exc_code_m(excCodeM), .bad_addr_m(badAddrM), .we(we), .wr_sel(wrSel),
    .wr_data(wrData), .rd_sel(rdSel), .rd_data(rdData), .eret(eret),
    .int_req(intReq), .epc(epc), .exl(exl)
  );

  cp0_exc_ctrl #(.NUM_HWINT(2)) dut2 (
    .clk(clk), .reset(reset), .hw_int(hwInt2), .pc_m(pcM), .bd_m(bdM),
    .exc_code_m(excCode2), .bad_addr_m(badAddrM), .we(we2), .wr_sel(wrSel2),
    .wr_data(wrData2), .rd_sel(rdSel2), .rd_data(rdData2), .eret(eret2),
    .int_req(intReq2), .epc(epc2), .exl(exl2)
  );

  // Scoreboard
  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t expQ[$];
  int   passCnt  = 0;
  int   totalCnt = 0;

  task automatic expectVal(input string n, input logic [31:0] v);
    expQ.push_back('{name: n, val: v});
  endtask

  task automatic checkOut(input logic [31:0] act);
    exp_t e;
    totalCnt++;
    if (expQ.size() == 0) begin
      $display("FAIL scoreboard_empty: got %h, nothing expected", act);
    end else begin
      e = expQ.pop_front();
      if (act === e.val) passCnt++;
      else $display("FAIL %s: got %h required %h", e.name, act, e.val);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rdChk(input logic [4:0] s, input string n, input logic [31:0] v);
    rdSel = s;
    #1;
    expectVal(n, v);
    checkOut(rdData);
  endtask

  task automatic wr(input logic [4:0] s, input logic [31:0] d);
    cyc();
    we = 1'b1; wrSel = s; wrData = d;
    cyc();
    we = 1'b0;
  endtask

  // Register access vectors: write, same-cycle read (old value), next read
  typedef struct {
    string       name;
    logic [4:0]  sel;
    logic [31:0] data;
    logic [31:0] expBefore;
    logic [31:0] expAfter;
  } vec_t;

  vec_t vecs[7];

  localparam logic [31:0] BadExp =
`ifdef CP0_BADVADDR_EN
    32'h0000_0003;
`else
    32'h0000_0000;
`endif

  initial begin
    vecs[0] = '{"sr_all",      5'd12, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_FC03};
    vecs[1] = '{"cause_ro",    5'd13, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{"prid_ro",     5'd15, 32'h0000_0000, 32'h2020_0707, 32'h2020_0707};
    vecs[3] = '{"epc_wr",      5'd14, 32'h0000_3103, 32'h0000_0000, 32'h0000_3103};
    vecs[4] = '{"sel8_ro",     5'd8,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{"unmapped",    5'd3,  32'h0000_0005, 32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{"sr_clr",      5'd12, 32'h0000_0000, 32'h0000_FC03, 32'h0000_0000};

    reset = 1'b0;
    hwInt = 6'h3F; pcM = 32'd0; bdM = 1'b0; excCodeM = 5'd12; badAddrM = 32'd0;
    we = 1'b0; wrSel = 5'd0; wrData = 32'd0; rdSel = 5'd12; eret = 1'b0;
    hwInt2 = 2'b00; excCode2 = 5'd0; we2 = 1'b0; wrSel2 = 5'd0; wrData2 = 32'd0;
    rdSel2 = 5'd13; eret2 = 1'b0;

    // Reset holds outputs low even with an exception code and interrupts driven
    @(posedge clk); @(posedge clk); #2;
    expectVal("rst_int_req", 32'd0); checkOut({31'd0, intReq});
    expectVal("rst_exl", 32'd0);     checkOut({31'd0, exl});
    expectVal("rst_epc", 32'd0);     checkOut(epc);
    rdChk(5'd12, "rst_sr", 32'd0);
    rdChk(5'd13, "rst_cause", 32'd0);
    hwInt = 6'h00; excCodeM = 5'd0;
    reset = 1'b1;

    // Register table
    for (int i = 0; i < 7; i++) begin
      cyc();
      we = 1'b1; wrSel = vecs[i].sel; wrData = vecs[i].data; rdSel = vecs[i].sel;
      #1;
      expectVal({vecs[i].name, "_pre"}, vecs[i].expBefore); checkOut(rdData);
      cyc();
      we = 1'b0;
      #1;
      expectVal({vecs[i].name, "_post"}, vecs[i].expAfter); checkOut(rdData);
    end

    // Interrupt latency through a two-flop synchroniser
    wr(5'd12, 32'h0000_0401);
    hwInt[0] = 1'b1; pcM = 32'h0000_3010; bdM = 1'b0;
    #1; expectVal("irq_lat0", 32'd0); checkOut({31'd0, intReq});
    cyc(); expectVal("irq_lat1", 32'd0); #1; checkOut({31'd0, intReq});
    cyc(); expectVal("irq_lat2", 32'd1); #1; checkOut({31'd0, intReq});
    cyc();
    hwInt[0] = 1'b0;
    #1;
    expectVal("irq_exl", 32'd1);         checkOut({31'd0, exl});
    expectVal("irq_req_off", 32'd0);     checkOut({31'd0, intReq});
    expectVal("irq_epc", 32'h0000_3010); checkOut(epc);
    rdChk(5'd13, "irq_cause", 32'h0000_0400);
    rdChk(5'd12, "irq_sr", 32'h0000_0403);

    // Exception in a delay slot with interrupts disabled
    wr(5'd12, 32'h0000_0000);
    cyc();
    excCodeM = 5'd12; bdM = 1'b1; pcM = 32'h0000_3008;
    #1; expectVal("ov_req", 32'd1); checkOut({31'd0, intReq});
    cyc();
    excCodeM = 5'd0; bdM = 1'b0;
    #1;
    expectVal("ov_exl", 32'd1);         checkOut({31'd0, exl});
    expectVal("ov_epc", 32'h0000_3004); checkOut(epc);
    rdChk(5'd14, "ov_epc_rd", 32'h0000_3004);
    rdChk(5'd13, "ov_cause", 32'h8000_0030);

    // Interrupt beats a same-cycle exception and mtc0
    hwInt[0] = 1'b1;
    cyc(); cyc(); cyc();
    wr(5'd12, 32'h0000_0401);
    excCodeM = 5'd10; we = 1'b1; wrSel = 5'd12; wrData = 32'h0; pcM = 32'h0000_3020;
    #1; expectVal("prio_req", 32'd1); checkOut({31'd0, intReq});
    cyc();
    we = 1'b0; excCodeM = 5'd0;
    #1;
    expectVal("prio_exl", 32'd1);         checkOut({31'd0, exl});
    expectVal("prio_epc", 32'h0000_3020); checkOut(epc);
    rdChk(5'd13, "prio_cause", 32'h0000_0400);
    rdChk(5'd12, "prio_sr_kept", 32'h0000_0403);

    // mtc0 EPC followed by eret in the same cycle
    hwInt[0] = 1'b0;
    cyc(); cyc(); cyc();
    we = 1'b1; wrSel = 5'd14; wrData = 32'h0000_3100; eret = 1'b1;
    #1;
    expectVal("eret_bypass", 32'h0000_3100); checkOut(epc);
    expectVal("eret_req", 32'd0);            checkOut({31'd0, intReq});
    cyc();
    we = 1'b0; eret = 1'b0;
    #1;
    expectVal("eret_exl", 32'd0); checkOut({31'd0, exl});
    rdChk(5'd14, "eret_epc_rd", 32'h0000_3100);
    rdChk(5'd12, "eret_sr", 32'h0000_0401);

    // Reset asserted during a take
    cyc();
    excCodeM = 5'd12; pcM = 32'h0000_4000;
    #1; expectVal("rtake_req", 32'd1); checkOut({31'd0, intReq});
    #2; reset = 1'b0;
    #1;
    expectVal("rtake_req_rst", 32'd0); checkOut({31'd0, intReq});
    @(posedge clk); #2;
    expectVal("rtake_exl", 32'd0); checkOut({31'd0, exl});
    expectVal("rtake_epc", 32'd0); checkOut(epc);
    excCodeM = 5'd0; reset = 1'b1;
    #1;
    rdChk(5'd14, "rtake_epc_rd", 32'd0);
    rdChk(5'd12, "rtake_sr", 32'd0);
    rdChk(5'd13, "rtake_cause", 32'd0);

    // Address error: BadVAddr capture
    cyc();
    excCodeM = 5'd4; badAddrM = 32'h0000_0003; pcM = 32'h0000_5000;
    #1; expectVal("adel_req", 32'd1); checkOut({31'd0, intReq});
    cyc();
    excCodeM = 5'd0;
    #1;
    rdChk(5'd8, "badvaddr", BadExp);
    rdChk(5'd13, "adel_cause", 32'h0000_0010);

    // Narrow instance: two interrupt lines
    cyc();
    hwInt2 = 2'b11; we2 = 1'b1; wrSel2 = 5'd12; wrData2 = 32'hFFFF_FC00;
    cyc();
    we2 = 1'b0;
    cyc(); cyc();
    rdSel2 = 5'd13; #1;
    expectVal("n2_cause", 32'h0000_0C00); checkOut(rdData2);
    rdSel2 = 5'd12; #1;
    expectVal("n2_sr", 32'h0000_0C00); checkOut(rdData2);
    expectVal("n2_req", 32'd0); checkOut({31'd0, intReq2});

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 SHALL provide parameter NUM_HWINT, default 6, meaning hardware interrupt line count (legal range 1..6).
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, meaning flop stages on each hw_int line (legal range 1..3).
REQ-003 SHALL provide parameter PRID_VALUE, default 32'h2020_0707, meaning constant read from PRId.
REQ-004 SHALL provide port: clk  in  1  rising-edge clock.
REQ-005 SHALL provide port: reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL provide port: hw_int  in  NUM_HWINT  level interrupt requests, asynchronous to clk.
REQ-007 SHALL provide port: pc_m  in  32  PC of the instruction in M stage.
REQ-008 SHALL provide port: bd_m  in  1  M-stage instruction is in a branch delay slot.
REQ-009 SHALL provide port: exc_code_m  in  5  M-stage exception code; 0 means no exception.
REQ-010 SHALL provide port: bad_addr_m  in  32  faulting address, used only under CP0_BADVADDR_EN.
REQ-011 SHALL provide ports: we  in  1  mtc0 strobe; wr_sel  in  5  target register; wr_data  in  32  write data.
REQ-012 SHALL provide ports: rd_sel  in  5  mfc0 register select; rd_data  out  32  combinational read data.
REQ-013 SHALL provide port: eret  in  1  eret in M stage.
REQ-014 SHALL provide ports: int_req  out  1  take exception/interrupt this cycle; epc  out  32  return address; exl  out  1  SR.EXL.

Function
REQ-015 SHALL map registers as SR=12, Cause=13, EPC=14, PRId=15; all other selects SHALL read 0.
REQ-016 SHALL lay out SR as IM at [10 +: NUM_HWINT], EXL at bit 1, IE at bit 0; all other SR bits SHALL read 0.
REQ-017 SHALL lay out Cause as BD at bit 31, IP at [10 +: NUM_HWINT], ExcCode at [6:2]; all other Cause bits SHALL read 0.
REQ-018 SHALL register each hw_int line through SYNC_STAGES flops, then load Cause.IP with the synchronised value every cycle (level, not latched).
REQ-019 SHALL compute int_pending = IE & ~EXL & |(IP & IM), and exc_pending = (exc_code_m != 0) & ~EXL.
REQ-020 SHALL drive int_req = int_pending | exc_pending, combinationally, in the same cycle.
REQ-021 SHALL give interrupts priority over exceptions: when int_pending, ExcCode SHALL become 0; otherwise ExcCode SHALL become exc_code_m.
REQ-022 SHALL, at the clock edge where int_req=1, set EXL=1, set BD=bd_m, and set EPC = bd_m ? pc_m-4 : pc_m, with bits [1:0] forced to 0.
REQ-023 SHALL accept mtc0 writes to SR and EPC only; writes to Cause, PRId and unmapped selects SHALL be ignored.
REQ-024 SHALL suppress a same-cycle mtc0 write when int_req=1, so that the take wins.
REQ-025 SHALL clear EXL on eret at the next edge; int_req is necessarily 0 in that cycle because EXL=1.
REQ-026 SHALL bypass epc to wr_data when we=1 and wr_sel=14 in the same cycle, so an mtc0 immediately followed by eret returns to the new value.
REQ-027 SHALL make rd_data reflect register state before the current edge, with no write-to-read bypass.

Reset
REQ-028 SHALL, while reset=0, clear SR, Cause, EPC, BadVAddr and all synchroniser flops to 0, and hold int_req=0, exl=0, epc=0.
REQ-029 SHALL let an assertion of reset in the middle of an interrupt take override it; no partial EPC/EXL update SHALL survive.

Configuration
REQ-030 SHALL, when macro CP0_BADVADDR_EN is defined, implement BadVAddr at select 8 and load it with bad_addr_m on a non-interrupt take whose exc_code_m is 4 or 5.
REQ-031 SHALL, when CP0_BADVADDR_EN is undefined, omit the BadVAddr flops, read select 8 as 0, and leave bad_addr_m unused.

Structure
REQ-032 SHALL place register selects, bit positions and ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12) in shared package cp0_pkg.
REQ-033 SHALL implement the hw_int synchroniser as sub-module int_sync, parametrised by width and stage count.

Verification
REQ-034 SHALL cover: SR=32'h0000_0401, hw_int[0] rises, pc_m=32'h0000_3010, bd_m=0 -> int_req=1 exactly 2 cycles later, EPC=32'h0000_3010, ExcCode=0, EXL=1.
REQ-035 SHALL cover: exc_code_m=12, bd_m=1, pc_m=32'h0000_3008, SR.IE=0 -> int_req=1 the same cycle, EPC=32'h0000_3004, Cause[31]=1, Cause[6:2]=12.
REQ-036 SHALL cover: interrupt pending plus exc_code_m=10 in the same cycle -> ExcCode=0; a same-cycle mtc0 to SR with 32'h0 is ignored.
REQ-037 SHALL cover: EXL=1, we=1, wr_sel=14, wr_data=32'h0000_3100, eret=1 -> epc=32'h0000_3100 that cycle, EXL=0 next cycle.
REQ-038 SHALL cover: NUM_HWINT=2, with hw_int=2'b11 and IM all ones -> Cause read = 32'h0000_0C00, and IP bits [15:12] read 0.
REQ-039 SHALL cover: with CP0_BADVADDR_EN defined, exc_code_m=4 and bad_addr_m=32'h0000_0003 -> rd_sel=8 reads 32'h0000_0003; with the macro undefined, rd_sel=8 reads 0.
